// File: rtl/voice_mix_scheduler.sv
// Round-robin voice poller: gathers one sample per voice, mixes, attenuates,
// saturates and pushes a mono-as-stereo word into the audio FIFO.
module voice_mix_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int SAMPLE_W    = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           RUN,
  input  logic [NUM_VOICES-1:0]          VOICE_EN,
  output logic [NUM_VOICES-1:0]          REQ,
  input  logic [NUM_VOICES-1:0]          ACK,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] SAMPLE,
  input  logic [1:0]                     MASTER_SHIFT,
  input  logic                           FIFO_FULL,
  output logic                           FIFO_WRITE,
  output logic [2*SAMPLE_W-1:0]          FIFO_DATA,
  output logic                           BUSY,
  output logic                           TIMEOUT_ERR,
  output logic [7:0]                     CLIP_CNT
);
  localparam int IW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, POLL, SCALE, WRITE} state_t;

  state_t                            state, state_nxt;
  logic [IW-1:0]                     idx, nidx;
  logic                              slot_en;
  logic [TW-1:0]                     tcnt;
  logic signed [ACC_W-1:0]           acc, sample_ext, shifted;
  logic signed [SAMPLE_W-1:0]        sat;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] smp;
  logic                              ack_i, tmo_hit, slot_done, last_slot;
  logic                              clip_hi, clip_lo, start;

  assign smp        = SAMPLE;
  assign nidx       = idx + 1'b1;
  assign ack_i      = ACK[idx];
  assign tmo_hit    = (tcnt == TW'(ACK_TIMEOUT - 1));
  // A disabled slot costs exactly one cycle and contributes nothing.
  assign slot_done  = !slot_en || ack_i || tmo_hit;
  assign last_slot  = (idx == IW'(NUM_VOICES - 1));
  assign start      = RUN && !FIFO_FULL;
  assign sample_ext = {{(ACC_W-SAMPLE_W){smp[idx][SAMPLE_W-1]}}, smp[idx]};
  assign shifted    = acc >>> MASTER_SHIFT;
  assign clip_hi    = shifted > SMAX;
  assign clip_lo    = shifted < SMIN;
  assign sat        = clip_hi ? SMAX[SAMPLE_W-1:0] :
                      clip_lo ? SMIN[SAMPLE_W-1:0] : shifted[SAMPLE_W-1:0];

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_req
    assign REQ[i] = (state == POLL) && slot_en && (idx == IW'(i));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    FIFO_WRITE = 1'b0;
    BUSY       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = POLL;
      POLL:  if (slot_done && last_slot) state_nxt = SCALE;
      SCALE: state_nxt = WRITE;
      WRITE: if (!FIFO_FULL) begin
               FIFO_WRITE = 1'b1;
               state_nxt  = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx         <= '0;
      slot_en     <= 1'b0;
      tcnt        <= '0;
      acc         <= '0;
      FIFO_DATA   <= '0;
      TIMEOUT_ERR <= 1'b0;
      CLIP_CNT    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc     <= '0;
          idx     <= '0;
          tcnt    <= '0;
          slot_en <= VOICE_EN[0];
        end
        POLL: if (slot_done) begin
          if (slot_en && ack_i)            acc <= acc + sample_ext;
          else if (slot_en && tmo_hit)     TIMEOUT_ERR <= 1'b1;
          tcnt <= '0;
          // Enable is latched on slot entry so mid-slot changes are ignored.
          if (!last_slot) begin
            idx     <= nidx;
            slot_en <= VOICE_EN[nidx];
          end
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        SCALE: begin
          FIFO_DATA <= {sat, sat};
          if ((clip_hi || clip_lo) && CLIP_CNT != 8'hFF) CLIP_CNT <= CLIP_CNT + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench for voice_mix_scheduler with combinational voice responders.
module tb_voice_mix_scheduler;
  localparam int NV = 4;
  localparam int SW = 16;
  localparam int TO = 15;

  logic              CLK = 1'b0;
  logic              RESET_N, RUN, FIFO_FULL, FIFO_WRITE, BUSY, TIMEOUT_ERR;
  logic [NV-1:0]     VOICE_EN, REQ, ACK, ack_mask;
  logic [NV*SW-1:0]  SAMPLE;
  logic [1:0]        MASTER_SHIFT;
  logic [2*SW-1:0]   FIFO_DATA;
  logic [7:0]        CLIP_CNT;

  int vectors = 0;
  int errors  = 0;

  voice_mix_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .VOICE_EN(VOICE_EN), .REQ(REQ),
    .ACK(ACK), .SAMPLE(SAMPLE), .MASTER_SHIFT(MASTER_SHIFT), .FIFO_FULL(FIFO_FULL),
    .FIFO_WRITE(FIFO_WRITE), .FIFO_DATA(FIFO_DATA), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR), .CLIP_CNT(CLIP_CNT)
  );

  always #5 CLK = ~CLK;
  assign ACK = REQ & ack_mask;

  // Mid-cycle monitor: counts cycles, REQ-high cycles per voice and writes.
  int          cyc = 0, wr_cnt = 0, wr_cyc = 0, busy_start = 0;
  int          req_cnt [NV];
  logic [31:0] wr_data = '0;
  logic        busy_q = 1'b0;
  initial for (int i = 0; i < NV; i++) req_cnt[i] = 0;
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (BUSY && !busy_q) busy_start = cyc;
    busy_q = BUSY;
    for (int i = 0; i < NV; i++) if (REQ[i]) req_cnt[i] = req_cnt[i] + 1;
    if (FIFO_WRITE) begin
      wr_cnt  = wr_cnt + 1;
      wr_data = FIFO_DATA;
      wr_cyc  = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_samples(input int a, input int b, input int c, input int d);
    SAMPLE = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic start_frame();
    RUN = 1'b1;
    step(1);
    RUN = 1'b0;
  endtask

  task automatic wait_write(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_cnt > base) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  // Runs one frame; returns write count delta and captured data.
  task automatic run_frame(input logic [NV-1:0] en, input logic [NV-1:0] mask,
                           input logic [1:0] shift, input int a, input int b,
                           input int c, input int d, output int nwr);
    int base;
    bit ok;
    VOICE_EN = en; ack_mask = mask; MASTER_SHIFT = shift;
    set_samples(a, b, c, d);
    base = wr_cnt;
    start_frame();
    wait_write(base, ok);
    step(3);
    nwr = wr_cnt - base;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: no write seen, required one write");
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RUN = 1'b0; FIFO_FULL = 1'b0; VOICE_EN = '1; ack_mask = '1;
    MASTER_SHIFT = 2'd0; SAMPLE = '0;
    step(3);
    vectors++;
    if ({REQ, FIFO_WRITE, BUSY, TIMEOUT_ERR} !== '0 || FIFO_DATA !== '0 || CLIP_CNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: REQ=%b WR=%b BUSY=%b TERR=%b DATA=%h CLIP=%0d, required all zero",
               REQ, FIFO_WRITE, BUSY, TIMEOUT_ERR, FIFO_DATA, CLIP_CNT);
    end
    RESET_N = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    int n;
    run_frame(4'hF, 4'hF, 2'd0, 1000, 1000, 1000, 1000, n);
    vectors++;
    if (n !== 1 || wr_data !== 32'h0FA0_0FA0) begin
      errors++; $display("FAIL basic_mix: writes=%0d data=%h, required 1 / 0fa00fa0", n, wr_data);
    end
    // Write lands in the (NV+2)-th busy cycle.
    vectors++;
    if (wr_cyc - busy_start !== NV + 1) begin
      errors++; $display("FAIL basic_latency: %0d, required %0d", wr_cyc - busy_start, NV + 1);
    end
    vectors++;
    if (CLIP_CNT !== 8'd0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL basic_clip_busy: clip=%0d busy=%b, required 0/0", CLIP_CNT, BUSY);
    end
  endtask

  task automatic test_clip();
    int n;
    run_frame(4'hF, 4'hF, 2'd0, 30000, 30000, 30000, 30000, n);
    vectors++;
    if (wr_data !== 32'h7FFF_7FFF || CLIP_CNT !== 8'd1) begin
      errors++; $display("FAIL clip_pos: data=%h clip=%0d, required 7fff7fff / 1", wr_data, CLIP_CNT);
    end
    run_frame(4'hF, 4'hF, 2'd2, 30000, 30000, 30000, 30000, n);
    vectors++;
    if (wr_data !== 32'h7530_7530 || CLIP_CNT !== 8'd1) begin
      errors++; $display("FAIL clip_shift2: data=%h clip=%0d, required 75307530 / 1", wr_data, CLIP_CNT);
    end
    run_frame(4'hF, 4'hF, 2'd0, -32768, -32768, -32768, -32768, n);
    vectors++;
    if (wr_data !== 32'h8000_8000 || CLIP_CNT !== 8'd2) begin
      errors++; $display("FAIL clip_neg: data=%h clip=%0d, required 80008000 / 2", wr_data, CLIP_CNT);
    end
  endtask

  task automatic test_enable();
    int n;
    int r1, r3;
    r1 = req_cnt[1]; r3 = req_cnt[3];
    run_frame(4'b0101, 4'hF, 2'd0, 100, 5000, 200, 5000, n);
    vectors++;
    if (wr_data !== 32'h012C_012C) begin
      errors++; $display("FAIL enable_mix: data=%h, required 012c012c", wr_data);
    end
    vectors++;
    if (req_cnt[1] - r1 !== 0 || req_cnt[3] - r3 !== 0) begin
      errors++; $display("FAIL enable_req: req1=%0d req3=%0d cycles, required 0/0",
                         req_cnt[1] - r1, req_cnt[3] - r3);
    end
    vectors++;
    if (wr_cyc - busy_start !== NV + 1) begin
      errors++; $display("FAIL enable_latency: %0d, required %0d", wr_cyc - busy_start, NV + 1);
    end
  endtask

  task automatic test_timeout();
    int n;
    int r1;
    r1 = req_cnt[1];
    vectors++;
    if (TIMEOUT_ERR !== 1'b0) begin
      errors++; $display("FAIL timeout_pre: terr=%b, required 0", TIMEOUT_ERR);
    end
    run_frame(4'hF, 4'b1101, 2'd0, 10, 10, 10, 10, n);
    vectors++;
    if (wr_data !== 32'h001E_001E || TIMEOUT_ERR !== 1'b1) begin
      errors++; $display("FAIL timeout_mix: data=%h terr=%b, required 001e001e / 1", wr_data, TIMEOUT_ERR);
    end
    vectors++;
    if (req_cnt[1] - r1 !== TO) begin
      errors++; $display("FAIL timeout_req_len: %0d, required %0d", req_cnt[1] - r1, TO);
    end
    run_frame(4'hF, 4'hF, 2'd0, 1, 1, 1, 1, n);
    vectors++;
    if (TIMEOUT_ERR !== 1'b1 || wr_data !== 32'h0004_0004) begin
      errors++; $display("FAIL timeout_sticky: terr=%b data=%h, required 1 / 00040004", TIMEOUT_ERR, wr_data);
    end
  endtask

  task automatic test_fifo_full();
    int base, fall;
    VOICE_EN = 4'hF; ack_mask = 4'hF; MASTER_SHIFT = 2'd0;
    set_samples(1, 2, 3, 4);
    base = wr_cnt;
    start_frame();
    FIFO_FULL = 1'b1;
    step(10);
    vectors++;
    if (FIFO_DATA !== 32'h000A_000A || BUSY !== 1'b1) begin
      errors++; $display("FAIL full_hold_early: data=%h busy=%b, required 000a000a / 1", FIFO_DATA, BUSY);
    end
    step(10);
    vectors++;
    if (wr_cnt !== base || FIFO_DATA !== 32'h000A_000A) begin
      errors++; $display("FAIL full_hold: writes=%0d data=%h, required 0 / 000a000a", wr_cnt - base, FIFO_DATA);
    end
    FIFO_FULL = 1'b0;
    fall = cyc;
    step(4);
    vectors++;
    if (wr_cnt - base !== 1 || wr_data !== 32'h000A_000A || wr_cyc !== fall + 1) begin
      errors++; $display("FAIL full_release: writes=%0d data=%h at+%0d, required 1 / 000a000a / +1",
                         wr_cnt - base, wr_data, wr_cyc - fall);
    end
  endtask

  task automatic test_run_drop();
    int base, rsum;
    bit ok;
    VOICE_EN = 4'hF; ack_mask = 4'hF; MASTER_SHIFT = 2'd0;
    set_samples(5, 5, 5, 5);
    base = wr_cnt;
    RUN = 1'b1;
    step(2);
    RUN = 1'b0;
    wait_write(base, ok);
    step(2);
    rsum = req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3];
    step(12);
    vectors++;
    if (!ok || wr_cnt - base !== 1 || wr_data !== 32'h0014_0014) begin
      errors++; $display("FAIL run_drop_frame: writes=%0d data=%h, required 1 / 00140014", wr_cnt - base, wr_data);
    end
    vectors++;
    if (req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3] - rsum !== 0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL run_drop_idle: extra req cycles=%0d busy=%b, required 0 / 0",
                         req_cnt[0] + req_cnt[1] + req_cnt[2] + req_cnt[3] - rsum, BUSY);
    end
  endtask

  task automatic test_reset_midframe();
    int base, n;
    VOICE_EN = 4'hF; ack_mask = 4'b1101; MASTER_SHIFT = 2'd0;
    set_samples(7, 7, 7, 7);
    base = wr_cnt;
    start_frame();
    step(4);
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (REQ !== '0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: REQ=%b busy=%b, required 0 / 0", REQ, BUSY);
    end
    step(3);
    RESET_N = 1'b1;
    step(1);
    vectors++;
    if (wr_cnt !== base || TIMEOUT_ERR !== 1'b0 || CLIP_CNT !== 8'd0 || FIFO_DATA !== '0) begin
      errors++; $display("FAIL reset_mid_clear: writes=%0d terr=%b clip=%0d data=%h, required 0/0/0/0",
                         wr_cnt - base, TIMEOUT_ERR, CLIP_CNT, FIFO_DATA);
    end
    run_frame(4'hF, 4'hF, 2'd0, 1000, 1000, 1000, 1000, n);
    vectors++;
    if (n !== 1 || wr_data !== 32'h0FA0_0FA0 || TIMEOUT_ERR !== 1'b0) begin
      errors++; $display("FAIL reset_mid_next: writes=%0d data=%h terr=%b, required 1 / 0fa00fa0 / 0",
                         n, wr_data, TIMEOUT_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_enable();
    test_timeout();
    test_fifo_full();
    test_run_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
